// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HI
    } rx_state_t;

    localparam int UART_SYNC_STAGES = 2;
    localparam int MIN_BAUD_DIV     = 8;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: flop-chain synchroniser for asynchronous single-bit inputs.
// RST_VAL sets the reset level of every stage, so an idle-high line never reads as an edge.
module uart_sync2
    import uart_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [UART_SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ff <= {UART_SYNC_STAGES{RST_VAL}};
        else
            ff <= {ff[UART_SYNC_STAGES-2:0], d};
    end

    assign q = ff[UART_SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime baud divisor, start-glitch reject, frame/overrun flags.
// Define UART_RX_PARITY_EN to add par_en/par_odd inputs, a PARITY state and the parity_err output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              clr_rdy,
`ifdef UART_RX_PARITY_EN
    input  logic              par_en,
    input  logic              par_odd,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rdy,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int BC_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    logic              rxs;
    logic              tick;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_in;
    logic [DIV_W-1:0]  baud_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic              par_on;
    logic              par_bit;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rxs)
    );

    // Divisors below the minimum cannot place a mid-bit sample reliably
    assign div_in = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;
    assign tick   = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div        <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rdy        <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_on     <= 1'b0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (state != IDLE)
                baud_cnt <= tick ? div - 1'b1 : baud_cnt - 1'b1;
            if (clr_rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                IDLE: if (!rxs) begin
                    state    <= START;
                    busy     <= 1'b1;
                    div      <= div_in;
                    baud_cnt <= div_in >> 1;
                    bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                    par_on   <= par_en;
`endif
                end
                START: if (tick) begin
                    state <= rxs ? IDLE : DATA;
                    busy  <= ~rxs;
                end
                DATA: if (tick) begin
                    shreg   <= {rxs, shreg[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BC_W'(DATA_W - 1))
`ifdef UART_RX_PARITY_EN
                        state <= par_on ? PARITY : STOP;
`else
                        state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    par_bit <= rxs;
                    state   <= STOP;
                end
`endif
                // Set beats a same-cycle clr_rdy so a freshly completed word is never lost
                STOP: if (tick) begin
                    rx_data   <= shreg;
                    rdy       <= 1'b1;
                    frame_err <= ~rxs;
                    overrun   <= overrun | rdy;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par_on & (^shreg ^ par_bit ^ par_odd);
`endif
                    state     <= rxs ? IDLE : WAIT_HI;
                    busy      <= ~rxs;
                end
                WAIT_HI: if (rxs) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames checked every cycle against a frame-level timing model.
// Define UART_RX_PARITY_EN to also exercise a 7-bit parity instance.
module tb_uart_rx_cfg;

    localparam int DW = 8;

    typedef struct {
        int          edge_n;
        logic [DW-1:0] data;
        logic        ferr;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_main;
    logic          clr_rdy = 1'b0;
    logic [15:0]   baud_div = 16'd32;
    logic [DW-1:0] rx_data;
    logic          rdy, frame_err, overrun, busy;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   t0;
    logic clr_q = 1'b0;
    logic rdy_d = 1'b0;

    ev_t           q[$];
    logic [DW-1:0] m_data = '0;
    logic          m_rdy = 1'b0, m_ferr = 1'b0, m_ov = 1'b0;
    logic          nr, no;

    always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
    logic       sel7 = 1'b0;
    logic       rx7;
    logic       parity_err;
    logic [6:0] rx_data7;
    logic       rdy7, ferr7, ov7, busy7, perr7;
    assign rx_main = sel7 ? 1'b1 : rx;
    assign rx7     = sel7 ? rx : 1'b1;

    uart_rx_cfg #(.DATA_W(7), .DIV_W(16)) dut7 (
        .clk(clk), .rst_n(rst_n), .RX(rx7), .baud_div(16'd16), .clr_rdy(1'b0),
        .par_en(1'b1), .par_odd(1'b0), .parity_err(perr7),
        .rx_data(rx_data7), .rdy(rdy7), .frame_err(ferr7), .overrun(ov7), .busy(busy7)
    );
`else
    assign rx_main = rx;
`endif

    uart_rx_cfg #(.DATA_W(DW), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx_main), .baud_div(baud_div), .clr_rdy(clr_rdy),
`ifdef UART_RX_PARITY_EN
        .par_en(1'b0), .par_odd(1'b0), .parity_err(parity_err),
`endif
        .rx_data(rx_data), .rdy(rdy), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sends one frame starting at the current negedge; the word appears at the stop-bit
    // mid-sample: 2 sync edges, 1 detect edge, div/2+1 edges to the start sample, then div per bit.
    task automatic send(input logic [8:0] d, input int nb, input logic stop_b, input int div,
                        input bit has_par, input logic par_b, input bit push, input int alt_div);
        ev_t e;
        e.edge_n = cyc + 4 + (div >> 1) + (nb + int'(has_par) + 1) * div;
        e.data   = d[DW-1:0];
        e.ferr   = ~stop_b;
        if (push) q.push_back(e);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        if (alt_div > 0) baud_div = 16'(alt_div);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (div) @(negedge clk);
        end
        if (has_par) begin
            rx = par_b;
            repeat (div) @(negedge clk);
        end
        rx = stop_b;
        repeat (div) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        clr_q <= clr_rdy;
    end

    always @(negedge clk) begin
        rdy_d <= rdy;
        if (rdy && !rdy_d) rise_cyc <= cyc;
    end

    // Model: word state changes only at predicted stop-sample edges or consumer acks
    always @(negedge clk) begin
        if (!rst_n) begin
            m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_ov = 1'b0;
            q.delete();
        end else begin
            nr = clr_q ? 1'b0 : m_rdy;
            no = clr_q ? 1'b0 : m_ov;
            if (q.size() > 0 && q[0].edge_n == cyc) begin
                no     = m_ov | m_rdy;
                nr     = 1'b1;
                m_data = q[0].data;
                m_ferr = q[0].ferr;
                void'(q.pop_front());
            end
            m_rdy = nr;
            m_ov  = no;
        end
        check("rx_data", 32'(rx_data), 32'(m_data));
        check("rdy", 32'(rdy), 32'(m_rdy));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun", 32'(overrun), 32'(m_ov));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(parity_err), 32'd0);
`endif
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        t0 = cyc;
        send(9'h0A5, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 0);
        check("A5 data", 32'(rx_data), 32'h0A5);
        check("A5 frame_err", 32'(frame_err), 32'd0);
        check("A5 latency ok", 32'(rise_cyc - t0 >= 302 && rise_cyc - t0 <= 308), 32'd1);
        repeat (4) @(negedge clk);
        check("A5 busy idle", 32'(busy), 32'd0);
        pulse_clr();
        repeat (5) @(negedge clk);

        // 10-cycle low glitch: rejected at the start sample
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch idle", 32'(busy), 32'd0);
        check("glitch rdy", 32'(rdy), 32'd0);
        repeat (10) @(negedge clk);

        // Stop bit low followed by a 40-bit break
        send(9'h03C, 8, 1'b0, 32, 1'b0, 1'b0, 1'b1, 0);
        check("3C rdy", 32'(rdy), 32'd1);
        check("3C frame_err", 32'(frame_err), 32'd1);
        check("3C data", 32'(rx_data), 32'h03C);
        pulse_clr();
        repeat (40 * 32) @(negedge clk);
        check("break busy", 32'(busy), 32'd1);
        check("break no frame", 32'(rdy), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break released", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);

        // Back-to-back words without ack; mid-frame divisor change must be ignored
        send(9'h011, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 8);
        baud_div = 16'd32;
        repeat (4) @(negedge clk);
        send(9'h022, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 0);
        check("ovr set", 32'(overrun), 32'd1);
        check("ovr data", 32'(rx_data), 32'h022);
        pulse_clr();
        check("ovr rdy cleared", 32'(rdy), 32'd0);
        check("ovr cleared", 32'(overrun), 32'd0);
        repeat (4) @(negedge clk);

        // Ack landing on the same edge as the next stop sample
        send(9'h081, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        fork
            send(9'h07E, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 0);
            begin
                repeat (3 + 16 + 9 * 32) @(negedge clk);
                pulse_clr();
            end
        join
        check("clr race rdy", 32'(rdy), 32'd1);
        check("clr race ovr", 32'(overrun), 32'd1);
        check("clr race data", 32'(rx_data), 32'h07E);
        repeat (4) @(negedge clk);

        // Reset in the middle of the data bits
        rx = 1'b0;
        repeat (3 * 32) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst rx_data", 32'(rx_data), 32'd0);
        check("rst rdy", 32'(rdy), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(9'h05A, 8, 1'b1, 32, 1'b0, 1'b0, 1'b1, 0);
        check("5A data", 32'(rx_data), 32'h05A);
        check("5A rdy", 32'(rdy), 32'd1);
        check("5A overrun", 32'(overrun), 32'd0);
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 7E1 on the second instance: 0x55 has four ones, so even parity bit is 0
        sel7 = 1'b1;
        send(9'h055, 7, 1'b1, 16, 1'b1, 1'b1, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("par bad perr", 32'(perr7), 32'd1);
        check("par bad data", 32'(rx_data7), 32'h55);
        check("par bad ferr", 32'(ferr7), 32'd0);
        send(9'h055, 7, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("par good perr", 32'(perr7), 32'd0);
        check("par good rdy", 32'(rdy7), 32'd1);
        check("par good ovr", 32'(ov7), 32'd1);
        check("par good busy", 32'(busy7), 32'd0);
        sel7 = 1'b0;
        repeat (10) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
